// File: rtl/tennis_scorekeeper.sv
// Tennis point/game scorekeeper: consumes point pulses, tracks server and match winner.
// Optional build macro GAME_HOLD_EN adds a post-game HOLD state that freezes point input.
//
// state | meaning
// PLAY  | accepting point pulses
// HOLD  | post-game freeze, counting down (GAME_HOLD_EN only)
// DONE  | match decided, outputs frozen until reset
module tennis_scorekeeper #(
    parameter int unsigned GAMES_TO_WIN = 6,
    parameter int unsigned HOLD_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_left,
    input  logic       point_right,
    output logic [2:0] left_pts,
    output logic [2:0] right_pts,
    output logic [3:0] left_games,
    output logic [3:0] right_games,
    output logic       server,
    output logic       game_won,
    output logic       match_over,
    output logic       winner,
    output logic       deuce
);

    if (GAMES_TO_WIN < 1 || GAMES_TO_WIN > 15) begin : g_bad_games
        $error("GAMES_TO_WIN must be in 1..15");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

`ifdef GAME_HOLD_EN
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;
    logic [CW-1:0] hold_cnt_q;
`else
    typedef enum logic [0:0] {PLAY, DONE} state_t;
`endif

    state_t     state_q;
    logic [2:0] left_q, right_q;
    logic [3:0] lgames_q, rgames_q;
    logic       server_q, game_won_q, match_over_q, winner_q;

    logic       valid;
    logic [2:0] x_raw, y_raw, x_pts, y_pts, x_d, y_d;
    logic [3:0] games_x_d;
    logic       win_game, final_game;

    always_comb begin
        valid      = point_left ^ point_right;
        x_raw      = point_left ? left_q  : right_q;
        y_raw      = point_left ? right_q : left_q;
        // Corrupted codes 5..7 score as if they were 0.
        x_pts      = (x_raw > 3'd4) ? 3'd0 : x_raw;
        y_pts      = (y_raw > 3'd4) ? 3'd0 : y_raw;
        x_d        = x_pts;
        y_d        = y_pts;
        win_game   = 1'b0;
        if (x_pts < 3'd3) begin
            x_d = x_pts + 3'd1;
        end else if (x_pts == 3'd3) begin
            if (y_pts < 3'd3)       win_game = 1'b1;
            else if (y_pts == 3'd3) x_d = 3'd4;
            else                    y_d = 3'd3;
        end else begin
            win_game = 1'b1;
        end
        games_x_d  = (point_left ? lgames_q : rgames_q) + 4'd1;
        final_game = (games_x_d == 4'(GAMES_TO_WIN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PLAY;
            left_q       <= '0;
            right_q      <= '0;
            lgames_q     <= '0;
            rgames_q     <= '0;
            server_q     <= 1'b0;
            game_won_q   <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 1'b0;
`ifdef GAME_HOLD_EN
            hold_cnt_q   <= '0;
`endif
        end else begin
            game_won_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (valid) begin
                        if (win_game) begin
                            left_q     <= '0;
                            right_q    <= '0;
                            game_won_q <= 1'b1;
                            server_q   <= ~server_q;
                            if (point_left) lgames_q <= games_x_d;
                            else            rgames_q <= games_x_d;
                            if (final_game) begin
                                match_over_q <= 1'b1;
                                winner_q     <= point_right;
                                state_q      <= DONE;
                            end
`ifdef GAME_HOLD_EN
                            else begin
                                hold_cnt_q <= CW'(HOLD_CYCLES - 1);
                                state_q    <= HOLD;
                            end
`endif
                        end else begin
                            left_q  <= point_left ? x_d : y_d;
                            right_q <= point_left ? y_d : x_d;
                        end
                    end
                end
`ifdef GAME_HOLD_EN
                HOLD: begin
                    if (hold_cnt_q == '0) state_q <= PLAY;
                    else                  hold_cnt_q <= hold_cnt_q - 1'b1;
                end
`endif
                DONE: ;
                default: state_q <= PLAY;
            endcase
        end
    end

    assign left_pts    = left_q;
    assign right_pts   = right_q;
    assign left_games  = lgames_q;
    assign right_games = rgames_q;
    assign server      = server_q;
    assign game_won    = game_won_q;
    assign match_over  = match_over_q;
    assign winner      = winner_q;
    assign deuce       = (left_q == 3'd3) && (right_q == 3'd3);

endmodule

// File: tb/tb_tennis_scorekeeper.sv
// Directed bench for tennis_scorekeeper: vector table plus match, reset and hold sequences.
module tb_tennis_scorekeeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       point_left = 1'b0, point_right = 1'b0;
    logic [2:0] left_pts, right_pts;
    logic [3:0] left_games, right_games;
    logic       server, game_won, match_over, winner, deuce;

    int passed = 0;
    int total  = 0;

    tennis_scorekeeper dut (
        .clk(clk), .reset(reset),
        .point_left(point_left), .point_right(point_right),
        .left_pts(left_pts), .right_pts(right_pts),
        .left_games(left_games), .right_games(right_games),
        .server(server), .game_won(game_won), .match_over(match_over),
        .winner(winner), .deuce(deuce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pl, pr;
        logic [2:0] lp, rp;
        logic [3:0] lg, rg;
        logic       srv, gw, mo, win, dc;
    } vec_t;

    vec_t vq[$];

    function automatic logic [18:0] pk(logic [2:0] lp, logic [2:0] rp, logic [3:0] lg,
                                       logic [3:0] rg, logic srv, logic gw, logic mo,
                                       logic win, logic dc);
        return {lp, rp, lg, rg, srv, gw, mo, win, dc};
    endfunction

    task automatic add(logic pl, logic pr, logic [2:0] lp, logic [2:0] rp, logic [3:0] lg,
                       logic [3:0] rg, logic srv, logic gw, logic mo, logic win, logic dc);
        vec_t v;
        v = '{pl, pr, lp, rp, lg, rg, srv, gw, mo, win, dc};
        vq.push_back(v);
    endtask

    task automatic chk(string name, logic [18:0] exp);
        logic [18:0] act;
        act = pk(left_pts, right_pts, left_games, right_games, server, game_won,
                 match_over, winner, deuce);
        total++;
        if (act !== exp)
            $display("FAIL %s: got lp=%0d rp=%0d lg=%0d rg=%0d srv=%b gw=%b mo=%b win=%b dc=%b, expected lp=%0d rp=%0d lg=%0d rg=%0d srv=%b gw=%b mo=%b win=%b dc=%b",
                     name, act[18:16], act[15:13], act[12:9], act[8:5], act[4], act[3], act[2],
                     act[1], act[0], exp[18:16], exp[15:13], exp[12:9], exp[8:5], exp[4],
                     exp[3], exp[2], exp[1], exp[0]);
        else
            passed++;
    endtask

    task automatic step(logic pl, logic pr);
        @(negedge clk);
        point_left  = pl;
        point_right = pr;
        @(posedge clk);
        #1;
        point_left  = 1'b0;
        point_right = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic srv_e;
        // Game 1: left holds serve 15-30-40-game, idle cycles between points.
        add(1,0, 1,0, 1'd0,0, 0,0,0,0,0);
        add(0,0, 1,0, 0,0, 0,0,0,0,0);
        add(1,0, 2,0, 0,0, 0,0,0,0,0);
        add(0,0, 2,0, 0,0, 0,0,0,0,0);
        add(1,0, 3,0, 0,0, 0,0,0,0,0);
        add(0,0, 3,0, 0,0, 0,0,0,0,0);
        add(1,0, 0,0, 1,0, 1,1,0,0,0);
        add(0,0, 0,0, 1,0, 1,0,0,0,0);
        // Game 2: deuce, advantage, back to deuce, right wins.
        add(0,1, 0,1, 1,0, 1,0,0,0,0);
        add(0,1, 0,2, 1,0, 1,0,0,0,0);
        add(0,1, 0,3, 1,0, 1,0,0,0,0);
        add(1,0, 1,3, 1,0, 1,0,0,0,0);
        add(1,0, 2,3, 1,0, 1,0,0,0,0);
        add(1,0, 3,3, 1,0, 1,0,0,0,1);
        add(1,0, 4,3, 1,0, 1,0,0,0,0);
        add(0,1, 3,3, 1,0, 1,0,0,0,1);
        add(0,1, 3,4, 1,0, 1,0,0,0,0);
        add(0,1, 0,0, 1,1, 0,1,0,0,0);
        add(0,0, 0,0, 1,1, 0,0,0,0,0);
        // Game 3: simultaneous pulses at 15-30 are ignored.
        add(1,0, 1,0, 1,1, 0,0,0,0,0);
        add(0,1, 1,1, 1,1, 0,0,0,0,0);
        add(0,1, 1,2, 1,1, 0,0,0,0,0);
        add(1,1, 1,2, 1,1, 0,0,0,0,0);
        add(0,0, 1,2, 1,1, 0,0,0,0,0);
        add(1,0, 2,2, 1,1, 0,0,0,0,0);
        add(1,0, 3,2, 1,1, 0,0,0,0,0);
        add(1,0, 0,0, 2,1, 1,1,0,0,0);
        add(0,0, 0,0, 2,1, 1,0,0,0,0);

        #1;
        chk("reset_state", pk(0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].pl, vq[i].pr);
            chk($sformatf("vec%0d", i), pk(vq[i].lp, vq[i].rp, vq[i].lg, vq[i].rg,
                vq[i].srv, vq[i].gw, vq[i].mo, vq[i].win, vq[i].dc));
        end

        // Left takes four straight games back-to-back to reach 6-1.
        srv_e = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) begin
                step(1, 0);
                if (p == 3) srv_e = ~srv_e;
                chk($sformatf("run_g%0d_p%0d", g, p),
                    pk((p == 3) ? 3'd0 : 3'(p + 1), 0, 4'(2 + g + ((p == 3) ? 1 : 0)), 1,
                       srv_e, p == 3, (p == 3) && (g == 3), 0, 0));
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1);
            chk($sformatf("done_frozen%0d", k), pk(0,0,6,1,1,0,1,0,0));
        end
        step(1, 0);
        chk("done_left_ignored", pk(0,0,6,1,1,0,1,0,0));

        // Async reset between edges at 30-15.
        do_reset();
        step(1, 0);
        step(1, 0);
        step(0, 1);
        chk("pre_reset_30_15", pk(2,1,0,0,0,0,0,0,0));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_clear", pk(0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_reset_release", pk(0,0,0,0,0,0,0,0,0));

        // Right wins the match 0-6.
        srv_e = 1'b0;
        for (int g = 0; g < 6; g++) begin
            for (int p = 0; p < 4; p++) step(0, 1);
            srv_e = ~srv_e;
            chk($sformatf("right_game%0d", g),
                pk(0, 0, 0, 4'(g + 1), srv_e, 1, g == 5, g == 5, 0));
        end

`ifdef GAME_HOLD_EN
        do_reset();
        for (int p = 0; p < 4; p++) step(1, 0);
        chk("hold_game", pk(0,0,1,0,1,1,0,0,0));
        for (int k = 1; k <= 8; k++) begin
            step(0, 1);
            chk($sformatf("hold_ignore%0d", k), pk(0,0,1,0,1,0,0,0,0));
        end
        step(0, 1);
        chk("hold_release", pk(0,1,1,0,1,0,0,0,0));
`else
        do_reset();
        for (int p = 0; p < 4; p++) step(1, 0);
        step(0, 1);
        chk("no_hold_immediate", pk(0,1,1,0,1,0,0,0,0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
